// File: rtl/drainer_pkg.sv
// Shared types and helpers for the load_drainer power-stress block.
package drainer_pkg;

    typedef enum logic [1:0] {
        ModeHold   = 2'd0,
        ModeAdd    = 2'd1,
        ModeLfsr   = 2'd2,
        ModeToggle = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRamp  = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } state_e;

    function automatic logic [31:0] seed(input int unsigned idx);
        return 32'(2 * idx + 1);
    endfunction

    // Right-shift Galois toggle masks; top bit always set so a nonzero state stays nonzero.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            4:       return 64'h0000_0000_0000_000C;
            5:       return 64'h0000_0000_0000_0014;
            6:       return 64'h0000_0000_0000_0030;
            7:       return 64'h0000_0000_0000_0060;
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_A300_0000;
            64:      return 64'hD800_0000_0000_0000;
            default: return (64'd1 << (width - 1)) | (64'd1 << (width - 2));
        endcase
    endfunction

    function automatic logic [15:0] lowest_bit(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

    function automatic logic [15:0] highest_bit(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/drainer_channel.sv
// One STAGES x WIDTH load chain; advances only on a prescaler tick while enabled.
module drainer_channel
    import drainer_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_en,
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_tail
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] w_next  [STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_next[k] = r_stage[k];
        end
        case (i_mode)
            ModeAdd: begin
                w_next[0] = r_stage[0] + i_seed;
                for (int k = 1; k < STAGES; k++) begin
                    w_next[k] = r_stage[k] + r_stage[k-1];
                end
            end
            ModeLfsr: begin
                // A zero LFSR would lock up, so reseed it instead of shifting.
                if (r_stage[0] == '0) begin
                    w_next[0] = i_seed;
                end else begin
                    w_next[0] = (r_stage[0] >> 1) ^ (r_stage[0][0] ? TAPS : '0);
                end
                for (int k = 1; k < STAGES; k++) begin
                    w_next[k] = r_stage[k-1] ^ {r_stage[k][WIDTH-2:0], r_stage[k][WIDTH-1]};
                end
            end
            ModeToggle: begin
                for (int k = 0; k < STAGES; k++) begin
                    w_next[k] = ~r_stage[k];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (i_tick && i_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= w_next[k];
            end
        end
    end

    assign o_tail = r_stage[STAGES-1];

endmodule

// File: rtl/load_drainer.sv
// Parametrised fabric/power-rail load: CHANNELS pipelined datapaths behind a clock-enable
// prescaler, switched on and off one channel at a time by a ramp/drain sequencer.
module load_drainer
    import drainer_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned STAGES      = 8,
    parameter int unsigned DIV_W       = 5,
    parameter int unsigned RAMP_CYCLES = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic [DIV_W-1:0]    i_div_sel,
    input  logic [CHANNELS-1:0] i_ch_mask,
    output logic [CHANNELS-1:0] o_active,
    output logic [1:0]          o_state,
    output logic                o_busy,
    output logic [WIDTH-1:0]    o_signature,
    output logic                o_heartbeat
);

    localparam int unsigned     CNT_W   = 2 ** DIV_W;
    localparam int unsigned     RC_W    = $clog2(RAMP_CYCLES) + 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_CYCLES - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_div_mask;
    logic                w_tick;
    state_e              r_state;
    logic [CHANNELS-1:0] r_active;
    logic [RC_W-1:0]     r_rc;
    logic                r_heartbeat;
    logic [WIDTH-1:0]    r_signature;
    logic [CHANNELS-1:0] w_kept;
    logic [CHANNELS-1:0] w_missing;
    logic [CHANNELS-1:0] w_add_bit;
    logic [CHANNELS-1:0] w_drop_bit;
    logic                w_step;
    logic [WIDTH-1:0]    w_tail [CHANNELS];
    logic [WIDTH-1:0]    w_sig;

    // div_sel is used combinationally so a new rate applies on the very next edge.
    assign w_div_mask = (CNT_W'(1) << i_div_sel) - CNT_W'(1);
    assign w_tick     = &(r_cnt | ~w_div_mask);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_kept     = r_active & i_ch_mask;
    assign w_missing  = i_ch_mask & ~w_kept;
    assign w_add_bit  = CHANNELS'(lowest_bit(16'(w_missing)));
    assign w_drop_bit = CHANNELS'(highest_bit(16'(w_kept)));
    assign w_step     = (r_rc == RC_LAST);

    // Masked-off channels drop out on every edge regardless of state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_active <= '0;
            r_rc     <= '0;
        end else begin
            r_active <= w_kept;
            r_rc     <= '0;
            case (r_state)
                StIdle: begin
                    if (i_enable && (|i_ch_mask)) r_state <= StRamp;
                end
                StRamp: begin
                    if (!i_enable) begin
                        r_state <= StDrain;
                    end else if (w_kept == i_ch_mask) begin
                        r_state <= StRun;
                    end else if (w_step) begin
                        r_active <= w_kept | w_add_bit;
                    end else begin
                        r_rc <= r_rc + RC_W'(1);
                    end
                end
                StRun: begin
                    if (!i_enable || (i_ch_mask == '0)) begin
                        r_state <= StDrain;
                    end else if (|w_missing) begin
                        r_state <= StRamp;
                    end
                end
                StDrain: begin
                    if (i_enable && (|i_ch_mask)) begin
                        r_state <= StRamp;
                    end else if (w_kept == '0) begin
                        r_state <= StIdle;
                    end else if (w_step) begin
                        r_active <= w_kept & ~w_drop_bit;
                    end else begin
                        r_rc <= r_rc + RC_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        drainer_channel #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_tick  (w_tick),
            .i_en    (r_active[g]),
            .i_mode  (mode_e'(i_mode)),
            .i_seed  (WIDTH'(seed(g))),
            .o_tail  (w_tail[g])
        );
    end

    always_comb begin
        w_sig = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sig = w_sig ^ w_tail[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_signature <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_signature <= w_sig;
            if (w_tick && (r_state != StIdle)) r_heartbeat <= ~r_heartbeat;
        end
    end

    assign o_active    = r_active;
    assign o_state     = r_state;
    assign o_busy      = (r_state != StIdle);
    assign o_signature = r_signature;
    assign o_heartbeat = r_heartbeat;

endmodule
